conv_loop_sequencer: RTL

Upstream stage of the convolution address controller. Generates the nested loop indices r, c (output row/column) and i, j (kernel row/column) that the controller turns into input-feature-map, weight and output-buffer addresses. Issues one index tuple per clock from a single start pulse, with a pause input, per-output-pixel and per-frame markers, and a drain phase that covers the controller's address pipeline. Asserts done only when the last output address has left that pipeline.

---
 rtl/conv_pkg.sv | 15 +
 rtl/wrap_counter.sv | 38 +++
 rtl/conv_loop_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution address controller and its loop sequencer.
// PIPE_DEPTH lives here so the sequencer's drain always matches the controller's address pipeline.
package conv_pkg;

  localparam int CONV_IDX_W      = 4;
  localparam int CONV_PIPE_DEPTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Index counter that steps by one on inc and wraps to zero after reaching max.
// Chained by at_max to form the nested loop indices of the sequencer.
module wrap_counter
  import conv_pkg::*;
#(
  parameter int IDX_W = CONV_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [IDX_W-1:0] max,
  output logic [IDX_W-1:0] value,
  output logic             at_max
);

  logic [IDX_W-1:0] value_q;
  logic [IDX_W-1:0] value_d;

  assign at_max = (value_q == max);

  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/conv_loop_sequencer.sv
// Issues the (r, c, i, j) loop tuples for one convolution frame, one per clock,
// then drains the downstream address pipeline before pulsing done.
module conv_loop_sequencer
  import conv_pkg::*;
#(
  parameter int OUT_SIZE   = 2,
  parameter int K          = 3,
  parameter int IDX_W      = CONV_IDX_W,
  parameter int PIPE_DEPTH = CONV_PIPE_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic [IDX_W-1:0] r,
  output logic [IDX_W-1:0] c,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             idx_valid,
  output logic             cell_last,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] OUT_MAX = IDX_W'(OUT_SIZE - 1);
  localparam logic [IDX_W-1:0] K_MAX   = IDX_W'(K - 1);
  localparam int               DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

  state_t             state_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               idx_valid_q;
  logic               busy_q;
  logic               done_q;

  logic j_max, i_max, c_max, r_max;
  logic at_end;
  logic advance;
  logic inc_i, inc_c, inc_r;

  assign at_end = r_max & c_max & i_max & j_max;

  // After a completed frame the indices rest on the last tuple, so a new start
  // steps them once and they wrap to (0,0,0,0); after reset they already sit at zero.
  assign advance = ((state_q == ST_RUN) && !hold && !at_end) ||
                   ((state_q == ST_IDLE) && start && at_end);

  assign inc_i = advance & j_max;
  assign inc_c = inc_i & i_max;
  assign inc_r = inc_c & c_max;

  wrap_counter #(.IDX_W(IDX_W)) u_j (
    .clock(clock), .reset(reset), .inc(advance), .max(K_MAX),   .value(j), .at_max(j_max)
  );
  wrap_counter #(.IDX_W(IDX_W)) u_i (
    .clock(clock), .reset(reset), .inc(inc_i),   .max(K_MAX),   .value(i), .at_max(i_max)
  );
  wrap_counter #(.IDX_W(IDX_W)) u_c (
    .clock(clock), .reset(reset), .inc(inc_c),   .max(OUT_MAX), .value(c), .at_max(c_max)
  );
  wrap_counter #(.IDX_W(IDX_W)) u_r (
    .clock(clock), .reset(reset), .inc(inc_r),   .max(OUT_MAX), .value(r), .at_max(r_max)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      idx_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= ST_RUN;
            idx_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            idx_valid_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (hold) begin
            idx_valid_q <= 1'b0;
          end else if (at_end) begin
            state_q     <= ST_DRAIN;
            drain_q     <= DRAIN_LOAD;
            idx_valid_q <= 1'b0;
          end else begin
            idx_valid_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          idx_valid_q <= 1'b0;
          if (drain_q == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign idx_valid  = idx_valid_q;
  assign cell_last  = idx_valid_q & i_max & j_max;
  assign frame_last = idx_valid_q & at_end;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
